// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - four-digit multiplexed seven-segment driver with shadow capture
// Anti-ghosting blanking, leading-zero suppression and a dash glyph for invalid BCD.
module seven_seg_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk_in,
  input  logic       sw,
  input  logic       load,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] dp_mask,
  input  logic       lzb,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       slot_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST    = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_V = CW'(BLANK_CYCLES);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][3:0] sd_q, sd_d;
  logic [3:0]      dpm_q, dpm_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic            tick_q, tick_d;

  logic            slot_blank;
  logic [3:0]      lead_blank;
  logic            zero3, zero2, zero1;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b0111111;
    endcase
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    sd_d  = sd_q;
    dpm_d = dpm_q;

    if (cnt_q == LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    if (load) begin
      sd_d  = {digit3, digit2, digit1, digit0};
      dpm_d = dp_mask;
    end

    // A digit is suppressed only when it and every digit to its left are exactly zero.
    zero3      = (sd_q[3] == 4'd0);
    zero2      = zero3 && (sd_q[2] == 4'd0);
    zero1      = zero2 && (sd_q[1] == 4'd0);
    lead_blank = {zero3, zero2, zero1, 1'b0} & {4{lzb}};

    slot_blank = (cnt_q < BLANK_V);
    an_d       = slot_blank ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d      = (slot_blank || lead_blank[idx_q]) ? 7'b1111111 : glyph(sd_q[idx_q]);
    dp_d       = slot_blank ? 1'b1 : ~dpm_q[idx_q];
    tick_d     = (cnt_q == LAST);
  end

  always_ff @(posedge clk_in) begin
    if (sw) begin
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      sd_q   <= '0;
      dpm_q  <= 4'd0;
      an_q   <= 4'b1111;
      seg_q  <= 7'b1111111;
      dp_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      sd_q   <= sd_d;
      dpm_q  <= dpm_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      tick_q <= tick_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign slot_tick = tick_q;

endmodule
